// File: rtl/cntr8_ctrl.sv
// cntr8_ctrl: command sequencer driving the step/load/inc/d_in controls of the 8-bit up/down counter.
// Optional sticky wrap flag is compiled in when CNTR8_CTRL_WRAP_FLAG_EN is defined.
module cntr8_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             step,
  output logic             load,
  output logic             inc,
  output logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wrap
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_s;
  logic             step_r, step_s;
  logic             load_r, load_s;
  logic             inc_r, inc_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;
  logic             dir_r, dir_s;
  logic [WIDTH-1:0] d_in_r, d_in_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] remaining_r, remaining_s;
  logic             accept_s;

  assign accept_s = ready_r & cmd_valid;

  // Next-state and datapath decode
  always_comb begin
    state_s     = state_r;
    d_in_s      = d_in_r;
    remaining_s = remaining_r;
    dir_s       = dir_r;
    result_s    = result_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_LOAD: begin
              state_s = ST_LOAD;
              d_in_s  = cmd_arg;
            end
            OP_CLEAR: begin
              state_s = ST_LOAD;
              d_in_s  = VAL_ZERO;
            end
            OP_UP, OP_DOWN: begin
              dir_s       = (cmd_op == OP_UP);
              remaining_s = cmd_arg;
              // A zero count skips straight to completion without touching the counter
              if (cmd_arg != VAL_ZERO) begin
                state_s = ST_STEP;
              end else begin
                state_s = ST_DONE;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_DONE;
      ST_STEP: begin
        remaining_s = remaining_r - VAL_ONE;
        if (remaining_r == VAL_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STEP;
        end
      end
      ST_DONE: begin
        result_s = cnt_val;
        state_s  = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every control is a flop output
  always_comb begin
    step_s  = (state_s == ST_LOAD) || (state_s == ST_STEP);
    load_s  = (state_s == ST_LOAD);
    inc_s   = 1'b0;
    if (state_s == ST_STEP) begin
      inc_s = dir_s;
    end else begin
      inc_s = 1'b0;
    end
    done_s  = (state_s == ST_DONE);
    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      step_r      <= 1'b0;
      load_r      <= 1'b0;
      inc_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      dir_r       <= 1'b0;
      d_in_r      <= VAL_ZERO;
      result_r    <= VAL_ZERO;
      remaining_r <= VAL_ZERO;
    end else begin
      state_r     <= state_s;
      step_r      <= step_s;
      load_r      <= load_s;
      inc_r       <= inc_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      ready_r     <= ready_s;
      dir_r       <= dir_s;
      d_in_r      <= d_in_s;
      result_r    <= result_s;
      remaining_r <= remaining_s;
    end
  end

  assign cmd_ready = ready_r;
  assign step      = step_r;
  assign load      = load_r;
  assign inc       = inc_r;
  assign d_in      = d_in_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;

`ifdef CNTR8_CTRL_WRAP_FLAG_EN
  logic wrap_sticky_r, wrap_sticky_s;
  logic wrap_r, wrap_s;

  // True when the step about to be applied to val crosses the modulo boundary
  function automatic logic wrap_hit(input logic dir, input logic [WIDTH-1:0] val);
    if (dir) begin
      wrap_hit = (val == {WIDTH{1'b1}});
    end else begin
      wrap_hit = (val == VAL_ZERO);
    end
  endfunction

  // Sticky wrap tracking, published alongside result
  always_comb begin
    wrap_sticky_s = wrap_sticky_r;
    wrap_s        = wrap_r;
    if (accept_s) begin
      wrap_sticky_s = 1'b0;
    end else if ((state_r == ST_STEP) && wrap_hit(dir_r, cnt_val)) begin
      wrap_sticky_s = 1'b1;
    end else begin
      wrap_sticky_s = wrap_sticky_r;
    end
    if (state_r == ST_DONE) begin
      wrap_s = wrap_sticky_r;
    end else begin
      wrap_s = wrap_r;
    end
  end

  // Wrap flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_sticky_r <= 1'b0;
      wrap_r        <= 1'b0;
    end else begin
      wrap_sticky_r <= wrap_sticky_s;
      wrap_r        <= wrap_s;
    end
  end

  assign wrap = wrap_r;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Scoreboard bench for cntr8_ctrl with a behavioural stand-in for the 8-bit counter.
module tb_cntr8_ctrl;

`ifdef CNTR8_CTRL_WRAP_FLAG_EN
  localparam logic W = 1'b1;
`else
  localparam logic W = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       step, load, inc, busy, done, wrap;
  logic [7:0] d_in, result;
  logic [7:0] cnt_r = 8'h00;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       wrp;
    int         steps;
    logic       exp_inc;
    logic       exp_load;
    logic [7:0] din;
    int         acc;
  } exp_t;

  exp_t q[$];

  cntr8_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .step(step), .load(load), .inc(inc),
    .d_in(d_in), .cnt_val(cnt_r), .busy(busy), .done(done), .result(result),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter being driven: updates only on step
  always @(posedge clk) begin
    if (step) begin
      if (load) cnt_r <= d_in;
      else if (inc) cnt_r <= cnt_r + 8'h01;
      else cnt_r <= cnt_r - 8'h01;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one command; expectation is queued at the edge where it is accepted
  task automatic send(input logic [1:0] op, input logic [7:0] arg,
                      input logic [7:0] res, input logic wrp, input int steps);
    exp_t e;
    int   waitc;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    waitc     = 0;
    while (!cmd_ready && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.res      = res;
    e.wrp      = wrp;
    e.steps    = steps;
    e.exp_inc  = (op == 2'b01);
    e.exp_load = (op == 2'b00) || (op == 2'b11);
    e.din      = (op == 2'b11) ? 8'h00 : arg;
    e.acc      = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", q.size(), 32'd0);
    @(negedge clk);
  endtask

  exp_t cur;
  logic pend = 1'b0;
  int   step_cnt = 0;

  // Monitor: per-step control checks, completion latency, result one cycle after done
  always @(negedge clk) begin
    if (pend) begin
      check("result", result, cur.res);
      check("wrap", wrap, cur.wrp);
      pend = 1'b0;
    end
    check("ready_vs_busy", cmd_ready, !busy);
    if (!busy) step_cnt = 0;
    if (step) begin
      step_cnt++;
      if (q.size() == 0) begin
        check("stray_step", 32'd1, 32'd0);
      end else begin
        check("load", load, q[0].exp_load);
        if (q[0].exp_load) check("d_in", d_in, q[0].din);
        else check("inc", inc, q[0].exp_inc);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        check("stray_done", 32'd1, 32'd0);
      end else begin
        cur = q.pop_front();
        // the cycle right after the accept edge is cycle 1
        check("steps", step_cnt, cur.steps);
        check("latency", cyc - cur.acc + 1, cur.steps + 1);
        check("done_step", step, 32'd0);
        pend = 1'b1;
        step_cnt = 0;
      end
    end
  end

  initial begin
    int sc;
    int w;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_step", step, 32'd0);
    check("rst_result", result, 32'h00);
    check("rst_done", done, 32'd0);
    check("rst_wrap", wrap, 32'd0);
    reset = 1'b0;

    send(2'b00, 8'h5A, 8'h5A, 1'b0, 1);   // LOAD 5A
    send(2'b01, 8'h04, 8'h5E, 1'b0, 4);   // UP 4, issued while LOAD still busy
    send(2'b00, 8'h01, 8'h01, 1'b0, 1);   // LOAD 01
    send(2'b10, 8'h03, 8'hFE, W,    3);   // DOWN 3 crosses zero
    send(2'b01, 8'h00, 8'hFE, 1'b0, 0);   // UP 0
    send(2'b11, 8'h77, 8'h00, 1'b0, 1);   // CLEAR ignores arg
    send(2'b00, 8'hFE, 8'hFE, 1'b0, 1);   // LOAD FE
    send(2'b01, 8'h03, 8'h01, W,    3);   // UP 3 wraps to 01
    send(2'b10, 8'h00, 8'h01, 1'b0, 0);   // DOWN 0
    send(2'b01, 8'hFF, 8'h00, W,    255); // UP 255 from 01
    send(2'b11, 8'h00, 8'h00, 1'b0, 1);   // CLEAR
    drain();

    send(2'b10, 8'hC8, 8'h00, 1'b0, 200); // DOWN 200, aborted by reset
    sc = 0;
    w  = 0;
    while (w < 400) begin
      if (step) sc++;
      if (sc == 50) break;
      @(negedge clk);
      w++;
    end
    check("abort_reach", sc, 32'd50);
    reset = 1'b1;
    @(negedge clk);
    check("abort_step", step, 32'd0);
    check("abort_busy", busy, 32'd0);
    check("abort_ready", cmd_ready, 32'd1);
    check("abort_done", done, 32'd0);
    check("abort_result", result, 32'h00);
    check("abort_wrap", wrap, 32'd0);
    if (q.size() != 0) void'(q.pop_front());
    reset = 1'b0;
    repeat (3) @(negedge clk);

    send(2'b00, 8'h33, 8'h33, 1'b0, 1);   // recovery after abort
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
